// File: rtl/mini_src_pkg.sv
// mini_src_pkg: shared widths, FIFO depth and read-FSM encoding for the input port
package mini_src_pkg;
    localparam int WORD_W       = 32;
    localparam int INPORT_DEPTH = 4;
    localparam int PTR_W        = 2;
    localparam int CNT_W        = 3;
    typedef enum logic [1:0] {IDLE, HOLD, POP} rd_state_t;
endpackage

// File: rtl/inport_fifo.sv
// inport_fifo: 4-deep word FIFO with wrap-around pointers
// ports: clk, clr (async), push/pop strobes, wdata in; head, head_next (word behind head), count out
module inport_fifo
    import mini_src_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] head,
    output logic [WORD_W-1:0] head_next,
    output logic [CNT_W-1:0]  count
);
    logic [WORD_W-1:0] mem [INPORT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wdata;
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + PTR_W'(1)];
endmodule

// File: rtl/in_port_unit.sv
// in_port_unit: buffered input port between an external device and the bus multiplexer
// ports: clk, clr (async); dev_data/dev_valid/dev_ready device handshake; In_Portout read strobe;
//        BusMuxIn_InPort bus word; inport_empty/full/count status; status_clr, inport_ovf/udf sticky flags
// macro INPORT_STATUS_EN enables the sticky overflow/underflow flags
module in_port_unit
    import mini_src_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic [WORD_W-1:0] dev_data,
    input  logic              dev_valid,
    output logic              dev_ready,
    input  logic              In_Portout,
    output logic [WORD_W-1:0] BusMuxIn_InPort,
    output logic              inport_empty,
    output logic              inport_full,
    output logic [CNT_W-1:0]  inport_count,
    input  logic              status_clr,
    output logic              inport_ovf,
    output logic              inport_udf
);
    rd_state_t         state, state_nx;
    logic [WORD_W-1:0] out_reg, out_nx, head, head_next;
    logic              pend, pend_nx, fifo_push, fifo_pop, enter, head_ok;
    assign inport_empty = inport_count == '0;
    assign inport_full  = inport_count == CNT_W'(INPORT_DEPTH);
    assign dev_ready    = !inport_full;
    assign fifo_push    = dev_valid && dev_ready;
    // pend remembers whether the read that entered HOLD found a word to remove
    assign fifo_pop     = state == POP && pend;
    assign enter        = In_Portout && state != HOLD;
    // on POP->HOLD the head being removed this edge is skipped
    assign head_ok      = fifo_pop ? inport_count > CNT_W'(1) : !inport_empty;
    inport_fifo u_fifo (
        .clk       (clk),
        .clr       (clr),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .wdata     (dev_data),
        .head      (head),
        .head_next (head_next),
        .count     (inport_count)
    );
    always_ff @(posedge clk or posedge clr)
        if (clr) state <= IDLE;
        else     state <= state_nx;
    always_comb begin
        state_nx = In_Portout ? HOLD : (state == HOLD ? POP : IDLE);
        out_nx   = enter ? (head_ok ? (fifo_pop ? head_next : head) : '0) : (In_Portout ? out_reg : '0);
        pend_nx  = enter ? head_ok : (state == HOLD && pend);
    end
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            out_reg <= '0;
            pend    <= 1'b0;
        end else begin
            out_reg <= out_nx;
            pend    <= pend_nx;
        end
    assign BusMuxIn_InPort = out_reg;
`ifdef INPORT_STATUS_EN
    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            inport_ovf <= 1'b0;
            inport_udf <= 1'b0;
        end else if (status_clr) begin
            inport_ovf <= 1'b0;
            inport_udf <= 1'b0;
        end else begin
            if (dev_valid && inport_full) inport_ovf <= 1'b1;
            if (state == IDLE && In_Portout && inport_empty) inport_udf <= 1'b1;
        end
`else
    logic unused_status_clr;
    assign unused_status_clr = status_clr;
    assign inport_ovf = 1'b0;
    assign inport_udf = 1'b0;
`endif
endmodule
